// File: rtl/bht_wr_sched.sv
// Write scheduler for the committed and speculative branch-history tables:
// buffers decoder corrections, applies speculative shifts, and rebuilds the
// speculative table from the committed one entry per cycle after a flush.
module bht_wr_sched #(
  parameter int HASH_BITS = 6,
  parameter int BHR_BITS  = 5,
  parameter int CQ_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 pred_valid_i,
  input  logic [HASH_BITS-1:0] pred_idx_i,
  input  logic                 pred_flag_i,
  input  logic                 corr_valid_i,
  input  logic [HASH_BITS-1:0] corr_idx_i,
  input  logic                 corr_flag_i,
  output logic                 corr_ready_o,
  output logic [HASH_BITS-1:0] spec_ridx_o,
  input  logic [BHR_BITS-1:0]  spec_rdata_i,
  output logic                 spec_we_o,
  output logic [HASH_BITS-1:0] spec_widx_o,
  output logic [BHR_BITS-1:0]  spec_wdata_o,
  output logic [HASH_BITS-1:0] cmt_ridx_o,
  input  logic [BHR_BITS-1:0]  cmt_rdata_i,
  output logic                 cmt_we_o,
  output logic [HASH_BITS-1:0] cmt_widx_o,
  output logic [BHR_BITS-1:0]  cmt_wdata_o,
  output logic                 busy_o
);

  localparam int PTR_W = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [HASH_BITS-1:0] LAST_IDX = {HASH_BITS{1'b1}};
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(CQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    REBUILD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [HASH_BITS-1:0] q_idx  [CQ_DEPTH];
  logic                 q_flag [CQ_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [HASH_BITS-1:0] rb_cnt, rb_cnt_nxt;

  logic q_empty, q_full, push, pop;

  // Shift a new outcome into the LSB of a history word.
  function automatic logic [BHR_BITS-1:0] shift_in(input logic [BHR_BITS-1:0] hist,
                                                   input logic                flag);
    return {hist[BHR_BITS-2:0], flag};
  endfunction

  assign q_empty      = (cnt == '0);
  assign q_full       = (cnt == FULL_CNT);
  assign corr_ready_o = !q_full && (state == IDLE);
  assign push         = corr_valid_i && corr_ready_o;
  assign pop          = !q_empty;
  assign busy_o       = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    rb_cnt_nxt   = rb_cnt;
    spec_ridx_o  = '0;
    spec_we_o    = 1'b0;
    spec_widx_o  = '0;
    spec_wdata_o = '0;
    cmt_ridx_o   = '0;
    cmt_we_o     = 1'b0;
    cmt_widx_o   = '0;
    cmt_wdata_o  = '0;

    // The head drains whenever present; a push this cycle is only visible next cycle.
    if (pop) begin
      cmt_we_o    = 1'b1;
      cmt_ridx_o  = q_idx[rd_ptr];
      cmt_widx_o  = q_idx[rd_ptr];
      cmt_wdata_o = shift_in(cmt_rdata_i, q_flag[rd_ptr]);
    end

    case (state)
      IDLE: begin
        if (flush_i) begin
          state_nxt = DRAIN;
        end else if (pred_valid_i) begin
          spec_we_o    = 1'b1;
          spec_ridx_o  = pred_idx_i;
          spec_widx_o  = pred_idx_i;
          spec_wdata_o = shift_in(spec_rdata_i, pred_flag_i);
        end
      end
      DRAIN: begin
        if (q_empty) begin
          state_nxt  = REBUILD;
          rb_cnt_nxt = '0;
        end
      end
      REBUILD: begin
        if (!pop) begin
          cmt_ridx_o = rb_cnt;
        end
        spec_we_o    = 1'b1;
        spec_widx_o  = rb_cnt;
        spec_wdata_o = cmt_rdata_i;
        if (flush_i) begin
          rb_cnt_nxt = '0;
        end else if (rb_cnt == LAST_IDX) begin
          state_nxt  = IDLE;
          rb_cnt_nxt = '0;
        end else begin
          rb_cnt_nxt = rb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        rb_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rb_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      rb_cnt <= rb_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= corr_idx_i;
      q_flag[wr_ptr] <= corr_flag_i;
    end
  end

endmodule

// File: tb/tb_bht_wr_sched.sv
// Randomized scoreboard bench for bht_wr_sched: owns both tables and checks
// every write against a queue/array reference model.
module tb_bht_wr_sched;
  localparam int HB = 6;
  localparam int BB = 5;
  localparam int D  = 4;
  localparam int N  = 64;

  logic clk, rst, flush_i, pred_valid_i, pred_flag_i, corr_valid_i, corr_flag_i;
  logic [HB-1:0] pred_idx_i, corr_idx_i;
  logic corr_ready_o, spec_we_o, cmt_we_o, busy_o;
  logic [HB-1:0] spec_ridx_o, spec_widx_o, cmt_ridx_o, cmt_widx_o;
  logic [BB-1:0] spec_rdata_i, spec_wdata_o, cmt_rdata_i, cmt_wdata_o;

  bht_wr_sched #(.HASH_BITS(HB), .BHR_BITS(BB), .CQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i), .pred_flag_i(pred_flag_i),
    .corr_valid_i(corr_valid_i), .corr_idx_i(corr_idx_i), .corr_flag_i(corr_flag_i),
    .corr_ready_o(corr_ready_o),
    .spec_ridx_o(spec_ridx_o), .spec_rdata_i(spec_rdata_i), .spec_we_o(spec_we_o),
    .spec_widx_o(spec_widx_o), .spec_wdata_o(spec_wdata_o),
    .cmt_ridx_o(cmt_ridx_o), .cmt_rdata_i(cmt_rdata_i), .cmt_we_o(cmt_we_o),
    .cmt_widx_o(cmt_widx_o), .cmt_wdata_o(cmt_wdata_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical tables owned by the bench; writes are ignored while reset is held.
  logic [BB-1:0] spec_tab [N];
  logic [BB-1:0] cmt_tab  [N];
  logic tb_init;
  assign spec_rdata_i = spec_tab[spec_ridx_o];
  assign cmt_rdata_i  = cmt_tab[cmt_ridx_o];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < N; i++) begin
        spec_tab[i] <= BB'((i * 5 + 2) % 32);
        cmt_tab[i]  <= BB'((i * 13 + 5) % 32);
      end
    end else if (!rst) begin
      if (spec_we_o) spec_tab[spec_widx_o] <= spec_wdata_o;
      if (cmt_we_o)  cmt_tab[cmt_widx_o]   <= cmt_wdata_o;
    end
  end

  // Reference model
  typedef struct packed { logic [HB-1:0] idx; logic [BB-1:0] data; } wr_t;
  typedef struct packed { logic [HB-1:0] idx; logic flag; } corr_t;
  typedef enum int { M_IDLE, M_DRAIN, M_REBUILD } mode_t;

  logic [BB-1:0] ref_spec [N];
  logic [BB-1:0] ref_cmt  [N];
  corr_t mq[$];
  wr_t   spec_exp[$];
  wr_t   cmt_exp[$];
  mode_t m_mode;
  int    m_pos;
  logic  m_busy, m_ready;
  logic  chk_en;

  int n_checks, n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    spec_exp.delete();
    cmt_exp.delete();
    m_mode = M_IDLE;
    m_pos  = 0;
  endtask

  task automatic model_step(input logic fl, input logic pv, input logic [HB-1:0] pi,
                            input logic pf, input logic cv, input logic [HB-1:0] ci,
                            input logic cf);
    int sz0;
    corr_t h;
    logic [BB-1:0] nv;
    sz0     = mq.size();
    m_busy  = (m_mode != M_IDLE);
    m_ready = (m_mode == M_IDLE) && (sz0 < D);
    if (sz0 > 0) begin
      h = mq.pop_front();
      nv = {ref_cmt[h.idx][BB-2:0], h.flag};
      ref_cmt[h.idx] = nv;
      cmt_exp.push_back('{idx: h.idx, data: nv});
    end
    if (m_mode == M_IDLE && !fl && pv) begin
      nv = {ref_spec[pi][BB-2:0], pf};
      ref_spec[pi] = nv;
      spec_exp.push_back('{idx: pi, data: nv});
    end
    if (m_mode == M_REBUILD) begin
      ref_spec[m_pos] = ref_cmt[m_pos];
      spec_exp.push_back('{idx: HB'(m_pos), data: ref_cmt[m_pos]});
    end
    if (cv && m_ready) mq.push_back('{idx: ci, flag: cf});
    case (m_mode)
      M_IDLE:  if (fl) m_mode = M_DRAIN;
      M_DRAIN: if (sz0 == 0) begin m_mode = M_REBUILD; m_pos = 0; end
      default: begin
        if (fl) m_pos = 0;
        else if (m_pos == N - 1) begin m_mode = M_IDLE; m_pos = 0; end
        else m_pos++;
      end
    endcase
  endtask

  // Monitor: compare every cycle's writes and status against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      wr_t e;
      chk("corr_ready", corr_ready_o, m_ready);
      chk("busy", busy_o, m_busy);
      chk("spec_we", spec_we_o, spec_exp.size() > 0);
      if (spec_we_o && spec_exp.size() > 0) begin
        e = spec_exp.pop_front();
        chk("spec_widx", spec_widx_o, e.idx);
        chk("spec_wdata", spec_wdata_o, e.data);
      end
      if (!spec_we_o) chk("spec_idle_out", {spec_widx_o, spec_wdata_o}, 0);
      chk("cmt_we", cmt_we_o, cmt_exp.size() > 0);
      if (cmt_we_o && cmt_exp.size() > 0) begin
        e = cmt_exp.pop_front();
        chk("cmt_widx", cmt_widx_o, e.idx);
        chk("cmt_wdata", cmt_wdata_o, e.data);
      end
      if (!cmt_we_o) chk("cmt_idle_out", {cmt_widx_o, cmt_wdata_o}, 0);
      spec_exp.delete();
      cmt_exp.delete();
      chk("q_count_bound", int'(dut.cnt) <= D, 1);
    end
  end

  task automatic cycle(input logic fl, input logic pv, input logic [HB-1:0] pi,
                       input logic pf, input logic cv, input logic [HB-1:0] ci,
                       input logic cf);
    @(posedge clk);
    #1;
    rst = 1'b0; tb_init = 1'b0; chk_en = 1'b1;
    flush_i = fl; pred_valid_i = pv; pred_idx_i = pi; pred_flag_i = pf;
    corr_valid_i = cv; corr_idx_i = ci; corr_flag_i = cf;
    model_step(fl, pv, pi, pf, cv, ci, cf);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; chk_en = 1'b0;
    flush_i = 0; pred_valid_i = 0; pred_idx_i = '0; pred_flag_i = 0;
    corr_valid_i = 0; corr_idx_i = '0; corr_flag_i = 0;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  // Counts busy cycles from the current one onward, bounded.
  task automatic count_busy(input int start, output int n);
    n = start;
    for (int k = 0; k < 300; k++) begin
      idle_cycle();
      #2;
      if (!busy_o) break;
      n++;
    end
  endtask

  initial begin
    int n;
    n_checks = 0; n_fail = 0;
    chk_en = 1'b0; tb_init = 1'b1; rst = 1'b1;
    flush_i = 0; pred_valid_i = 0; pred_idx_i = '0; pred_flag_i = 0;
    corr_valid_i = 0; corr_idx_i = '0; corr_flag_i = 0;
    for (int i = 0; i < N; i++) begin
      ref_spec[i] = BB'((i * 5 + 2) % 32);
      ref_cmt[i]  = BB'((i * 13 + 5) % 32);
    end
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    idle_cycle();
    #2;
    chk("rst_ready", corr_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_we", {spec_we_o, cmt_we_o}, 0);

    // Speculative shift: entry 7 holds 5'b00101
    cycle(1'b0, 1'b1, 6'd7, 1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("shift_we", spec_we_o, 1);
    chk("shift_widx", spec_widx_o, 7);
    chk("shift_wdata", spec_wdata_o, 5'b01011);

    // Back-to-back corrections: one pop per cycle keeps ready high
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, HB'(10 + i), i[0]);
    #2;
    chk("burst_ready", corr_ready_o, 1);
    idle_cycle();
    idle_cycle();

    // Flush with a correction pending plus one accepted in the flush cycle
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 6'd33, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 6'd34, 1'b0);
    count_busy(0, n);
    chk("flush_busy_len", n, 1 + 1 + N);

    // Flush mid-rebuild at counter 20
    idle_cycle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (21) idle_cycle();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    chk("restart_at_widx20", spec_widx_o, 20);
    idle_cycle();
    #2;
    chk("restart_widx", spec_widx_o, 0);
    count_busy(1, n);
    chk("restart_sweep_len", n, N);

    // Flush + predictor update + correction in the same cycle
    idle_cycle();
    cycle(1'b1, 1'b1, 6'd21, 1'b1, 1'b1, 6'd40, 1'b1);
    #2;
    chk("flush_pred_drop", spec_we_o, 0);
    count_busy(0, n);
    chk("flush_corr_busy_len", n, 1 + 1 + N);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), HB'($urandom_range(0, N - 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4, HB'($urandom_range(0, N - 1)),
            1'($urandom_range(0, 1)));
    end
    repeat (80) idle_cycle();

    // Reset in the middle of a rebuild
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (12) idle_cycle();
    do_reset();
    idle_cycle();
    #2;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", corr_ready_o, 1);
    repeat (3) idle_cycle();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bht_wr_sched.md
Name: bht_wr_sched

Overview:
Write scheduler for the two branch-history tables in the IF branch predictor.
- Committed table: decoder-corrected history.
- Speculative table: predictor-updated history.
- Corrections are buffered in a small queue and drained into the committed table one per cycle.
- Speculative shifts go straight to the speculative table.
- On a pipeline flush, the block drains pending corrections, then rebuilds the speculative table from the committed table one entry per cycle. This replaces a single-cycle whole-array copy.

Parameters:
HASH_BITS, 6, table index width; table has 2**HASH_BITS entries
BHR_BITS, 5, history bits per entry
CQ_DEPTH, 4, correction queue depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush_i  in  1  pipeline flush pulse
pred_valid_i  in  1  speculative history update request
pred_idx_i  in  HASH_BITS  hashed index of predicted branch
pred_flag_i  in  1  predicted direction
corr_valid_i  in  1  decoder correction valid
corr_idx_i  in  HASH_BITS  hashed index of corrected branch
corr_flag_i  in  1  actual direction
corr_ready_o  out  1  correction accepted when valid&&ready
spec_ridx_o  out  HASH_BITS  speculative table async read index
spec_rdata_i  in  BHR_BITS  speculative table read data
spec_we_o  out  1  speculative table write enable
spec_widx_o  out  HASH_BITS  speculative write index
spec_wdata_o  out  BHR_BITS  speculative write data
cmt_ridx_o  out  HASH_BITS  committed table async read index
cmt_rdata_i  in  BHR_BITS  committed table read data
cmt_we_o  out  1  committed table write enable
cmt_widx_o  out  HASH_BITS  committed write index
cmt_wdata_o  out  BHR_BITS  committed write data
busy_o  out  1  DRAIN or REBUILD; predictor lookups must be masked

Behaviour:
- States: IDLE, DRAIN, REBUILD.
- Reset: state=IDLE, queue empty, rebuild counter=0.
  - Outputs after reset: corr_ready_o=1, busy_o=0, spec_we_o=0, cmt_we_o=0.
  - All index and data outputs are 0 when their write enables are 0 and no request is active.
- Correction queue:
  - FIFO of {idx, flag}.
  - corr_ready_o = !full && state==IDLE.
  - Push on corr_valid_i && corr_ready_o.
  - No bypass: a push at cycle t drains at t+1 at the earliest.
- Drain (any state, queue non-empty):
  - cmt_we_o=1, cmt_ridx_o=cmt_widx_o=head.idx.
  - cmt_wdata_o={cmt_rdata_i[BHR_BITS-2:0], head.flag}.
  - Pop the head the same cycle. Simultaneous push and pop in IDLE is legal and leaves the count unchanged.
- Speculative update (IDLE && !flush_i && pred_valid_i):
  - spec_we_o=1, spec_ridx_o=spec_widx_o=pred_idx_i.
  - spec_wdata_o={spec_rdata_i[BHR_BITS-2:0], pred_flag_i}.
  - This path is combinational, zero latency.
- Predictor updates are silently dropped in DRAIN/REBUILD and in the cycle flush_i is high.
- State transitions:
  - IDLE + flush_i -> DRAIN. A correction accepted in the flush cycle is kept.
  - DRAIN: when the queue is empty, go to REBUILD next cycle with counter=0. An empty queue at entry costs one DRAIN cycle. flush_i has no effect.
  - REBUILD (queue empty, commit table static):
    - cmt_ridx_o=counter, spec_we_o=1, spec_widx_o=counter, spec_wdata_o=cmt_rdata_i.
    - counter increments each cycle.
    - At counter == 2**HASH_BITS-1, write the last entry and go to IDLE with counter=0.
  - flush_i during REBUILD restarts the counter at 0 next cycle and stays in REBUILD.
- busy_o = (state!=IDLE), registered state-derived.
- Total flush penalty = 1 + queue occupancy + 2**HASH_BITS cycles.
- rst mid-DRAIN/REBUILD: return to IDLE and empty the queue. Table contents are owned and reset externally.

Test Plan:
- Reset: hold rst 2 cycles -> corr_ready_o=1, busy_o=0, spec_we_o=cmt_we_o=0.
- Spec shift: spec_rdata_i=5'b00101, pred_valid=1, idx=7, flag=1 in IDLE -> same cycle spec_we_o=1, widx=7, wdata=5'b01011.
- Queue full: push 4 corrections back-to-back while holding cmt_rdata_i=0 -> corr_ready_o stays 1 (one pop per cycle). Each pops one cycle after its push with cmt_wdata_o={4'b0, flag}. A drain stall is unreachable, so the bench checks count<=CQ_DEPTH via assertion.
- Flush with 3 queued entries -> 3 cmt writes in DRAIN. REBUILD writes spec idx 0..63 with cmt_rdata_i. busy_o is high for 1+3+64=68 cycles, then IDLE. corr_ready_o is 0 throughout.
- Flush at REBUILD counter=20 -> next spec_widx_o=0, with a full 64-cycle sweep afterward.
- flush_i and pred_valid_i in the same cycle -> spec_we_o=0 and the predictor update is dropped. A simultaneous corr_valid is accepted and drained in DRAIN.
